// File: rtl/remote_comm_if.sv
`default_nettype none
// ============================================================================
//  Module      : remote_comm_if
//  Description : Command / serial-line bundle between the host side and the
//                remote_comm UART link (command strobe, status, response and
//                the TX/RX serial pins).
//  Revision    : 1.0 - initial release
// ============================================================================
interface remote_comm_if;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        TX;
   logic        RX;
   logic        busy;
   logic        cmd_sent;
   logic [7:0]  resp;
   logic        resp_rdy;

   // Host / stimulus side
   modport master (
      output cmd, send_cmd, RX,
      input  TX, busy, cmd_sent, resp, resp_rdy
   );

   // remote_comm side
   modport slave (
      input  cmd, send_cmd, RX,
      output TX, busy, cmd_sent, resp, resp_rdy
   );
endinterface
`default_nettype wire

// File: rtl/remote_comm.sv
`default_nettype none
// ============================================================================
//  Module      : remote_comm
//  Description : Sends a 16-bit command as two back-to-back 8N1 frames (high
//                byte first) and receives single-byte 8N1 responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module remote_comm #(
   parameter int BAUD_DIV = 2604
) (
   input  logic          clk,
   input  logic          rst,
   remote_comm_if.slave  bus
);

   localparam int              CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_HIGH = 2'd1,
      TX_LOW  = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // ---------------------------------------------------------------- TX ----
   tx_state_t        tx_state, tx_state_nxt;
   logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
   logic [3:0]       tx_idx, tx_idx_nxt;
   logic [15:0]      hold;
   logic [7:0]       tx_byte;
   logic             tx_bit;
   logic             tx_line;
   logic             busy_q;
   logic             cmd_sent_q;
   logic             accept;

   // Outputs are registered one cycle behind the state, so busy_q (not the
   // state) gates acceptance: busy stays high through the final idle cycle.
   assign accept = bus.send_cmd && (tx_state == TX_IDLE) && !busy_q;

   // TX next-state, bit timing and current line value
   always_comb begin
      tx_state_nxt = tx_state;
      tx_cnt_nxt   = tx_cnt;
      tx_idx_nxt   = tx_idx;
      tx_byte      = (tx_state == TX_HIGH) ? hold[15:8] : hold[7:0];
      tx_bit       = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (accept) begin
               tx_state_nxt = TX_HIGH;
               tx_cnt_nxt   = '0;
               tx_idx_nxt   = 4'd0;
            end
         end
         TX_HIGH, TX_LOW: begin
            if (tx_idx == 4'd0)
               tx_bit = 1'b0;
            else if (tx_idx <= 4'd8)
               tx_bit = tx_byte[3'(tx_idx - 4'd1)];
            if (tx_cnt == CNT_LAST) begin
               tx_cnt_nxt = '0;
               if (tx_idx == 4'd9) begin
                  tx_idx_nxt   = 4'd0;
                  tx_state_nxt = (tx_state == TX_HIGH) ? TX_LOW : TX_IDLE;
               end else begin
                  tx_idx_nxt = tx_idx + 4'd1;
               end
            end else begin
               tx_cnt_nxt = tx_cnt + CNT_W'(1);
            end
         end
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   // TX state register, holding register and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_idx     <= 4'd0;
         hold       <= 16'h0000;
         tx_line    <= 1'b1;
         busy_q     <= 1'b0;
         cmd_sent_q <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         tx_cnt   <= tx_cnt_nxt;
         tx_idx   <= tx_idx_nxt;
         if (accept)
            hold <= bus.cmd;
         tx_line <= tx_bit;
         busy_q  <= (tx_state != TX_IDLE);
         if (accept)
            cmd_sent_q <= 1'b0;
         else if ((tx_state == TX_IDLE) && busy_q)
            cmd_sent_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- RX ----
   rx_state_t        rx_state, rx_state_nxt;
   logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt, rx_cnt_inc;
   logic [2:0]       rx_idx, rx_idx_nxt;
   logic [7:0]       rx_shift, rx_shift_nxt;
   logic             rx_meta, rx_sync, rx_prev;
   logic             rx_good;
   logic [7:0]       resp_q;
   logic             resp_rdy_q;

   assign rx_cnt_inc = (rx_cnt == CNT_LAST) ? '0 : rx_cnt + CNT_W'(1);

   // RX next-state: edge detect, mid-bit sampling, framing check
   always_comb begin
      rx_state_nxt = rx_state;
      rx_cnt_nxt   = rx_cnt;
      rx_idx_nxt   = rx_idx;
      rx_shift_nxt = rx_shift;
      rx_good      = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            // The detect cycle counts as offset 0 of the start bit
            if (rx_prev && !rx_sync) begin
               rx_state_nxt = RX_START;
               rx_cnt_nxt   = CNT_W'(1);
               rx_idx_nxt   = 3'd0;
            end
         end
         RX_START: begin
            rx_cnt_nxt = rx_cnt_inc;
            if ((rx_cnt == CNT_HALF) && rx_sync)
               rx_state_nxt = RX_IDLE;       // start bit gone by mid-bit: glitch
            else if (rx_cnt == CNT_LAST)
               rx_state_nxt = RX_DATA;
         end
         RX_DATA: begin
            rx_cnt_nxt = rx_cnt_inc;
            if (rx_cnt == CNT_HALF)
               rx_shift_nxt = {rx_sync, rx_shift[7:1]};
            if (rx_cnt == CNT_LAST) begin
               if (rx_idx == 3'd7)
                  rx_state_nxt = RX_STOP;
               else
                  rx_idx_nxt = rx_idx + 3'd1;
            end
         end
         RX_STOP: begin
            rx_cnt_nxt = rx_cnt_inc;
            if (rx_cnt == CNT_HALF) begin
               rx_state_nxt = RX_IDLE;
               rx_good      = rx_sync;
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // RX synchronizer, state register and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_idx     <= 3'd0;
         rx_shift   <= 8'h00;
         resp_q     <= 8'h00;
         resp_rdy_q <= 1'b0;
      end else begin
         rx_meta  <= bus.RX;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_state_nxt;
         rx_cnt   <= rx_cnt_nxt;
         rx_idx   <= rx_idx_nxt;
         rx_shift <= rx_shift_nxt;
         // A completing frame takes priority over the clear from a new command
         if (rx_good) begin
            resp_q     <= rx_shift;
            resp_rdy_q <= 1'b1;
         end else if (accept) begin
            resp_rdy_q <= 1'b0;
         end
      end
   end

   assign bus.TX       = tx_line;
   assign bus.busy     = busy_q;
   assign bus.cmd_sent = cmd_sent_q;
   assign bus.resp     = resp_q;
   assign bus.resp_rdy = resp_rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_remote_comm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_remote_comm
//  Description : Self-checking bench for remote_comm (BAUD_DIV = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_comm;
   localparam int B = 16;

   logic       clk = 1'b0;
   logic       rst;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] model_resp;
   logic       model_rdy;

   remote_comm_if bus ();

   remote_comm #(.BAUD_DIV(B)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected TX level k cycles after the accepting edge
   function automatic logic exp_tx(input logic [15:0] c, input int k);
      int         frame, pos;
      logic [7:0] b;
      if (k < 1 || k > 20 * B) return 1'b1;
      frame = (k - 1) / (10 * B);
      pos   = ((k - 1) / B) % 10;
      b     = (frame == 0) ? c[15:8] : c[7:0];
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos - 1];
   endfunction

   // Called just after a negedge; returns at the negedge following acceptance
   task automatic pulse_send(input logic [15:0] c);
      bus.cmd      = c;
      bus.send_cmd = 1'b1;
      @(negedge clk);
      bus.send_cmd = 1'b0;
      model_rdy    = 1'b0;
   endtask

   // Checks TX/busy/cmd_sent for cycles 0..321 after acceptance; optionally
   // fires an extra request c2 at cycle intr_k which must be ignored
   task automatic check_frames(input logic [15:0] c, input string tag,
                               input int intr_k, input logic [15:0] c2);
      logic eb, es, et;
      for (int k = 0; k <= 20 * B + 1; k++) begin
         if (k > 0) @(negedge clk);
         if (k == intr_k) begin
            bus.cmd      = c2;
            bus.send_cmd = 1'b1;
         end else if (k == intr_k + 1) begin
            bus.send_cmd = 1'b0;
         end
         et = exp_tx(c, k);
         eb = (k >= 1 && k <= 20 * B);
         es = (k == 20 * B + 1);
         n_cmp++;
         if (bus.TX !== et) begin
            n_bad++;
            $display("FAIL %s tx k=%0d got %b exp %b", tag, k, bus.TX, et);
         end
         n_cmp++;
         if (bus.busy !== eb) begin
            n_bad++;
            $display("FAIL %s busy k=%0d got %b exp %b", tag, k, bus.busy, eb);
         end
         n_cmp++;
         if (bus.cmd_sent !== es) begin
            n_bad++;
            $display("FAIL %s cmd_sent k=%0d got %b exp %b", tag, k, bus.cmd_sent, es);
         end
      end
   endtask

   // Drives one 8N1 frame on RX, one bit per B cycles (160 negedges)
   task automatic drive_rx(input logic [7:0] b, input logic stop);
      bus.RX = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.RX = b[i];
         repeat (B) @(negedge clk);
      end
      bus.RX = stop;
      repeat (B) @(negedge clk);
      bus.RX = 1'b1;
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop, input string tag);
      drive_rx(b, stop);
      if (stop) begin
         model_resp = b;
         model_rdy  = 1'b1;
      end
      repeat (8) @(negedge clk);
      n_cmp++;
      if (bus.resp !== model_resp) begin
         n_bad++;
         $display("FAIL %s resp got %h exp %h", tag, bus.resp, model_resp);
      end
      n_cmp++;
      if (bus.resp_rdy !== model_rdy) begin
         n_bad++;
         $display("FAIL %s resp_rdy got %b exp %b", tag, bus.resp_rdy, model_rdy);
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (bus.cmd_sent !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (bus.cmd_sent !== 1'b1) begin
         n_bad++;
         $display("FAIL %s cmd_sent timeout got %b exp 1", tag, bus.cmd_sent);
      end
   endtask

   task automatic test_reset;
      rst          = 1'b1;
      bus.send_cmd = 1'b0;
      bus.cmd      = 16'h0000;
      bus.RX       = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_resp = 8'h00;
      model_rdy  = 1'b0;
      n_cmp++; if (bus.TX !== 1'b1)        begin n_bad++; $display("FAIL reset TX got %b exp 1", bus.TX); end
      n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset busy got %b exp 0", bus.busy); end
      n_cmp++; if (bus.cmd_sent !== 1'b0)  begin n_bad++; $display("FAIL reset cmd_sent got %b exp 0", bus.cmd_sent); end
      n_cmp++; if (bus.resp !== 8'h00)     begin n_bad++; $display("FAIL reset resp got %h exp 00", bus.resp); end
      n_cmp++; if (bus.resp_rdy !== 1'b0)  begin n_bad++; $display("FAIL reset resp_rdy got %b exp 0", bus.resp_rdy); end
   endtask

   task automatic test_calibrate;
      pulse_send(16'h2000);
      check_frames(16'h2000, "calibrate", -1, 16'h0000);
   endtask

   task automatic test_busy_request;
      pulse_send(16'h4123);
      check_frames(16'h4123, "busy_req", 100, 16'h6023);
   endtask

   task automatic test_response;
      rx_frame(8'hA5, 1'b1, "resp_a5");
      rx_frame(8'h3C, 1'b0, "resp_badstop");
      for (int i = 0; i < 6; i++)
         rx_frame(8'($urandom), ($urandom_range(0, 3) != 0), "resp_rand");
   endtask

   task automatic test_glitch;
      bus.RX = 1'b0;
      repeat (4) @(negedge clk);
      bus.RX = 1'b1;
      repeat (200) @(negedge clk);
      n_cmp++; if (bus.resp !== model_resp)    begin n_bad++; $display("FAIL glitch resp got %h exp %h", bus.resp, model_resp); end
      n_cmp++; if (bus.resp_rdy !== model_rdy) begin n_bad++; $display("FAIL glitch resp_rdy got %b exp %b", bus.resp_rdy, model_rdy); end
   endtask

   // RX load edge falls 155 posedges after RX drops at a negedge; the
   // request raised at the 154th following negedge is accepted on that edge
   task automatic test_coincidence;
      logic [7:0]  b;
      logic [15:0] c;
      b = 8'($urandom);
      c = 16'($urandom);
      fork
         drive_rx(b, 1'b1);
         begin
            repeat (154) @(negedge clk);
            bus.cmd      = c;
            bus.send_cmd = 1'b1;
            @(negedge clk);
            bus.send_cmd = 1'b0;
         end
      join
      model_resp = b;
      model_rdy  = 1'b1;
      n_cmp++; if (bus.resp !== model_resp)    begin n_bad++; $display("FAIL coincide resp got %h exp %h", bus.resp, model_resp); end
      n_cmp++; if (bus.resp_rdy !== model_rdy) begin n_bad++; $display("FAIL coincide resp_rdy got %b exp %b", bus.resp_rdy, model_rdy); end
      n_cmp++; if (bus.busy !== 1'b1)          begin n_bad++; $display("FAIL coincide busy got %b exp 1", bus.busy); end
      wait_done("coincide");
      @(negedge clk);
   endtask

   task automatic test_random_tx;
      logic [15:0] c, c2;
      for (int i = 0; i < 3; i++) begin
         c  = 16'($urandom);
         c2 = 16'($urandom);
         pulse_send(c);
         check_frames(c, "rand_tx", $urandom_range(1, 20 * B), c2);
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      pulse_send(16'($urandom));
      repeat (10 * B + 1 + 5 * B + 4) @(negedge clk);   // inside low-byte bit 5
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_resp = 8'h00;
      model_rdy  = 1'b0;
      n_cmp++; if (bus.TX !== 1'b1)       begin n_bad++; $display("FAIL rst_mid TX got %b exp 1", bus.TX); end
      n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL rst_mid busy got %b exp 0", bus.busy); end
      n_cmp++; if (bus.cmd_sent !== 1'b0) begin n_bad++; $display("FAIL rst_mid cmd_sent got %b exp 0", bus.cmd_sent); end
      n_cmp++; if (bus.resp !== 8'h00)    begin n_bad++; $display("FAIL rst_mid resp got %h exp 00", bus.resp); end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.TX !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid idle TX i=%0d got %b exp 1", i, bus.TX);
         end
      end
   endtask

   task automatic test_back_to_back;
      pulse_send(16'h5032);
      check_frames(16'h5032, "b2b_first", -1, 16'h0000);
      pulse_send(16'h6023);
      check_frames(16'h6023, "b2b_second", -1, 16'h0000);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      bus.RX       = 1'b1;
      bus.send_cmd = 1'b0;
      bus.cmd      = 16'h0000;
      @(negedge clk);
      test_reset();
      test_calibrate();
      @(negedge clk);
      test_busy_request();
      test_response();
      test_glitch();
      test_coincidence();
      test_random_tx();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
